// File: rtl/data_mem.sv
// MIPS data memory: 2**ADDR_WIDTH 32-bit words, byte/half/word stores, combinational extended loads.
// Optional DM_ALIGN_CHECK_EN adds a misalign output that suppresses misaligned accesses.
module data_mem #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dm_w,
  input  logic        dm_r,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  dm_op,
`ifdef DM_ALIGN_CHECK_EN
  output logic        misalign,
`endif
  output logic [31:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [2:0] OP_BS = 3'b001;
  localparam logic [2:0] OP_BU = 3'b010;
  localparam logic [2:0] OP_HS = 3'b011;
  localparam logic [2:0] OP_HU = 3'b100;

  logic [ADDR_WIDTH-1:0] idx;
  logic                  is_byte;
  logic                  is_half;
  logic                  is_word;
  logic                  access_ok;
  logic                  we;
  logic [3:0]            byte_en;
  logic [31:0]           wlane;
  logic [31:0]           rword;
  logic [7:0]            rbyte;
  logic [15:0]           rhalf;
  logic                  unused_addr_hi;

  // Upper address bits are deliberately dropped so addresses wrap.
  assign idx            = addr[ADDR_WIDTH+1:2];
  assign unused_addr_hi = ^addr[31:ADDR_WIDTH+2];

  assign is_byte = (dm_op == OP_BS) || (dm_op == OP_BU);
  assign is_half = (dm_op == OP_HS) || (dm_op == OP_HU);
  assign is_word = !is_byte && !is_half;

`ifdef DM_ALIGN_CHECK_EN
  assign misalign  = (dm_r || dm_w) &&
                     ((is_word && (addr[1:0] != 2'b00)) || (is_half && addr[0]));
  assign access_ok = !misalign;
`else
  assign access_ok = 1'b1;
`endif

  assign we = dm_w && access_ok;

  always_comb begin
    byte_en = 4'b1111;
    wlane   = wdata;
    if (is_byte) begin
      byte_en = 4'b0001 << addr[1:0];
      wlane   = {4{wdata[7:0]}};
    end else if (is_half) begin
      byte_en = addr[1] ? 4'b1100 : 4'b0011;
      wlane   = {2{wdata[15:0]}};
    end
  end

  // One storage array per byte lane so each lane has its own write enable.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_q [DEPTH];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            lane_q[i] <= '0;
          end
        end else if (we && byte_en[gi]) begin
          lane_q[idx] <= wlane[gi*8 +: 8];
        end
      end

      assign rword[gi*8 +: 8] = lane_q[idx];
    end
  endgenerate

  always_comb begin
    rbyte = rword[7:0];
    case (addr[1:0])
      2'b01:   rbyte = rword[15:8];
      2'b10:   rbyte = rword[23:16];
      2'b11:   rbyte = rword[31:24];
      default: rbyte = rword[7:0];
    endcase
    rhalf = addr[1] ? rword[31:16] : rword[15:0];
  end

  always_comb begin
    rdata = '0;
    if (rst_n && dm_r && access_ok) begin
      case (dm_op)
        OP_BS:   rdata = {{24{rbyte[7]}}, rbyte};
        OP_BU:   rdata = {24'd0, rbyte};
        OP_HS:   rdata = {{16{rhalf[15]}}, rhalf};
        OP_HU:   rdata = {16'd0, rhalf};
        default: rdata = rword;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem; covers both builds of DM_ALIGN_CHECK_EN.
module tb_data_mem;

  localparam int AW = 10;

  localparam logic [2:0] WD = 3'b000;
  localparam logic [2:0] BS = 3'b001;
  localparam logic [2:0] BU = 3'b010;
  localparam logic [2:0] HS = 3'b011;
  localparam logic [2:0] HU = 3'b100;

  logic        clk;
  logic        rst_n;
  logic        dm_w;
  logic        dm_r;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  dm_op;
  logic [31:0] rdata;
`ifdef DM_ALIGN_CHECK_EN
  logic        misalign;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  data_mem #(.ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dm_w  (dm_w),
    .dm_r  (dm_r),
    .addr  (addr),
    .wdata (wdata),
    .dm_op (dm_op),
`ifdef DM_ALIGN_CHECK_EN
    .misalign (misalign),
`endif
    .rdata (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
      $display("check %-14s addr=%h op=%0d rdata=%h ok", tag, addr, dm_op, obs);
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    dm_w  = 1'b1;
    dm_r  = 1'b0;
    dm_op = op;
    addr  = a;
    wdata = d;
    tick();
    dm_w  = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [2:0] op, input logic [31:0] a,
                    input logic [31:0] exp);
    dm_r  = 1'b1;
    dm_op = op;
    addr  = a;
    #1;
    check(tag, rdata, exp);
    dm_r  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    dm_w  = 1'b0;
    dm_r  = 1'b1;
    addr  = 32'd4;
    wdata = 32'd0;
    dm_op = WD;
    #1;
    check("rst_rdata", rdata, 32'd0);
    tick();
    rst_n = 1'b1;
    dm_r  = 1'b0;
    rd("post_rst", WD, 32'd4, 32'd0);

    // Word store/load
    wr(WD, 32'd4, 32'd2333);
    rd("wd_4", WD, 32'd4, 32'd2333);
    wr(WD, 32'd8, 32'd2433);
    rd("wd_8", WD, 32'd8, 32'd2433);
    rd("wd_4_kept", WD, 32'd4, 32'd2333);

    // Byte store/load
    wr(WD, 32'd0, 32'h1122_3344);
    wr(BS, 32'd1, 32'h0000_00FF);
    rd("byte_merge", WD, 32'd0, 32'h1122_FF44);
    rd("bs_1", BS, 32'd1, 32'hFFFF_FFFF);
    rd("bu_1", BU, 32'd1, 32'h0000_00FF);
    rd("bu_3", BU, 32'd3, 32'h0000_0011);
    rd("bs_0", BS, 32'd0, 32'h0000_0044);

    // Half store/load
    wr(WD, 32'h10, 32'hAABB_CCDD);
    wr(HS, 32'h12, 32'h0000_8001);
    rd("hs_12", HS, 32'h12, 32'hFFFF_8001);
    rd("hu_12", HU, 32'h12, 32'h0000_8001);
    rd("hu_10_kept", HU, 32'h10, 32'h0000_CCDD);
    rd("hs_10", HS, 32'h10, 32'hFFFF_CCDD);
    rd("wd_10", WD, 32'h10, 32'h8001_CCDD);

    // Reserved opcodes behave as word
    rd("op7_read", 3'b111, 32'h10, 32'h8001_CCDD);
    wr(3'b110, 32'h14, 32'h1234_5678);
    rd("op6_write", WD, 32'h14, 32'h1234_5678);

    // Read gating
    dm_r = 1'b0; dm_op = WD; addr = 32'd4;
    #1;
    check("dm_r_low", rdata, 32'd0);

    // Reset clears memory and blocks a concurrent write
    rst_n = 1'b0;
    dm_w  = 1'b1; dm_op = WD; addr = 32'd4; wdata = 32'hDEAD_BEEF;
    dm_r  = 1'b1;
    #1;
    check("rst_gate", rdata, 32'd0);
    tick();
    dm_w  = 1'b0;
    check("in_rst", rdata, 32'd0);
    rst_n = 1'b1;
    rd("clr_4", WD, 32'd4, 32'd0);
    rd("clr_8", WD, 32'd8, 32'd0);
    rd("clr_0", WD, 32'd0, 32'd0);
    rd("clr_10", WD, 32'h10, 32'd0);

    // Address wrap
    wr(WD, 32'd4 + 32'(4 * (1 << AW)), 32'hCAFE_BABE);
    rd("wrap_4", WD, 32'd4, 32'hCAFE_BABE);
    rd("wrap_hi", WD, 32'h8000_0004, 32'hCAFE_BABE);

    // Same-word read/write: old value until the edge, then new
    wr(WD, 32'd8, 32'h0101_0101);
    dm_r = 1'b1; dm_w = 1'b1; dm_op = WD; addr = 32'd8; wdata = 32'h0202_0202;
    #1;
    check("rw_before", rdata, 32'h0101_0101);
    tick();
    check("rw_after", rdata, 32'h0202_0202);
    dm_w = 1'b0; dm_r = 1'b0;

    wr(HU, 32'h12, 32'h0000_8001);
`ifdef DM_ALIGN_CHECK_EN
    dm_r = 1'b1; dm_op = WD; addr = 32'd4;
    #1;
    check("mis_aligned", {31'd0, misalign}, 32'd0);
    dm_r = 1'b0;
    dm_w = 1'b1; dm_op = WD; addr = 32'd6; wdata = 32'h5555_5555;
    #1;
    check("mis_wd_w", {31'd0, misalign}, 32'd1);
    tick();
    dm_w = 1'b0;
    rd("mis_wd_kept", WD, 32'd4, 32'hCAFE_BABE);
    dm_r = 1'b1; dm_op = HU; addr = 32'd3;
    #1;
    check("mis_hu_flag", {31'd0, misalign}, 32'd1);
    check("mis_hu_data", rdata, 32'd0);
    dm_op = BU;
    #1;
    check("mis_bu_flag", {31'd0, misalign}, 32'd0);
    dm_r = 1'b0;
    rd("mis_hu_13", HU, 32'h13, 32'd0);
`else
    rd("unal_wd_6", WD, 32'd6, 32'hCAFE_BABE);
    rd("unal_hu_13", HU, 32'h13, 32'h0000_8001);
    wr(WD, 32'd6, 32'h5555_5555);
    rd("unal_wd_w", WD, 32'd4, 32'h5555_5555);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
